// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared types and helpers for the key event debouncer
//
// Purpose: per-channel debounce state encoding and the counter width helper
//          used by key_debounce_chan.
// Ports:   none (package).

package key_debounce_pkg;

  // Per-channel debounce states.
  //   UP     : accepted released, idle
  //   DN_CHK : press seen, waiting for it to stay stable
  //   DOWN   : accepted pressed, timing towards a long press
  //   LONG   : long press reached, timing auto-repeat intervals
  //   UP_CHK : release seen while pressed, waiting for it to stay stable
  typedef enum logic [2:0] {
    UP     = 3'd0,
    DN_CHK = 3'd1,
    DOWN   = 3'd2,
    LONG   = 3'd3,
    UP_CHK = 3'd4
  } kstate_t;

  // Width of a counter that must hold values 0 .. max(a, b, c)-1.
  // The counter only ever reaches (limit - 1) because it is cleared on
  // every terminal count or state change, so clog2(max) bits suffice.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// rtl/key_debounce_chan.sv - one key channel: synchroniser, debounce FSM and event timer
//
// Purpose: conditions a single raw key pin into a debounced level plus
//          single-cycle press / release / long-press / auto-repeat events.
// Ports:
//   clk          in  1  system clock
//   rst          in  1  synchronous active-high reset
//   key_in       in  1  raw asynchronous key pin
//   key_level    out 1  debounced held state, 1 = pressed
//   key_press    out 1  one-cycle pulse on an accepted press
//   key_release  out 1  one-cycle pulse on an accepted release
//   key_long     out 1  one-cycle pulse once per press after LONG_CYC of hold
//   key_repeat   out 1  one-cycle pulse every REPEAT_CYC while long-pressed

module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter int REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int CW = cnt_width(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Raw pin level that means "not pressed"; the synchroniser resets to it
  // so no phantom press is seen coming out of reset.
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
  localparam logic RPT_ON   = (REPEAT_EN != 0);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  kstate_t       state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q,  long_d;
  logic          repeat_q, repeat_d;

  logic          pressed;

  // Two-flop synchroniser for the asynchronous pin.
  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
  end

  // Polarity-normalised pressed flag from the synchronised pin.
  assign pressed = sync2_q ^ IDLE_LVL;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      UP: begin
        if (pressed) begin
          state_d = DN_CHK;
          cnt_d   = '0;
        end
      end

      DN_CHK: begin
        if (!pressed) begin
          // Bounce: abandon silently.
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DOWN: begin
        if (!pressed) begin
          state_d = UP_CHK;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      LONG: begin
        if (!pressed) begin
          state_d = UP_CHK;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          // Counter keeps cycling even when repeat is disabled; only the
          // pulse is suppressed.
          cnt_d    = '0;
          repeat_d = RPT_ON;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      UP_CHK: begin
        if (pressed) begin
          // Release glitch: back to DOWN, so the long-press timer restarts
          // and a fresh key_long may be issued.
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = UP;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = UP;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= IDLE_LVL;
      sync2_q   <= IDLE_LVL;
      state_q   <= UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign key_repeat  = repeat_q;

endmodule

// File: rtl/key_event_debounce.sv
// rtl/key_event_debounce.sv - multi-channel key conditioner top level
//
// Purpose: N_KEYS independent debounce channels turning raw key pins into
//          a debounced level and registered single-cycle key events.
// Ports:
//   clk          in  1       system clock, single domain
//   rst          in  1       synchronous active-high reset
//   key_in       in  N_KEYS  raw asynchronous key pins
//   key_level    out N_KEYS  debounced held state, 1 = pressed
//   key_press    out N_KEYS  one-cycle pulse on an accepted press
//   key_release  out N_KEYS  one-cycle pulse on an accepted release
//   key_long     out N_KEYS  one-cycle pulse once per press after LONG_CYC of hold
//   key_repeat   out N_KEYS  one-cycle pulse every REPEAT_CYC while long-pressed

module key_event_debounce #(
  parameter int N_KEYS       = 5,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter int REPEAT_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_debounce_chan #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .REPEAT_EN    (REPEAT_EN)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in[g]),
      .key_level   (key_level[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g]),
      .key_long    (key_long[g]),
      .key_repeat  (key_repeat[g])
    );
  end

endmodule
